// File: rtl/pmem_loader.sv
// ============================================================================
// Module      : pmem_loader
// Description : Boot-time program-memory writer for the LWRISC8 core.
//               Parses a framed byte stream
//                   SYNC, CNT_L, CNT_H, N x {HI, LO}, CSUM
//               packs each HI/LO pair into a 12-bit instruction word, and
//               writes the words to program memory from address 0 upward.
//               The core is held in clear until a whole frame has been
//               written and its checksum verified.
// Ports       : clk          - sole clock, rising edge
//               rst_n        - asynchronous active-low reset
//               i_in_data    - incoming byte
//               i_in_valid   - i_in_data valid this cycle
//               o_in_ready   - loader accepts a byte this cycle
//               o_pmem_we    - program-memory write strobe (one cycle/word)
//               o_pmem_addr  - program-memory write address
//               o_pmem_wdata - 12-bit instruction word
//               o_core_clr   - holds the core in clear while high
//               o_done       - load completed successfully (sticky)
//               o_err        - last frame failed (sticky until next SYNC)
//               o_err_code   - 1 checksum, 2 format, 3 timeout, 0 none
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmem_loader #(
    parameter int          AW      = 11,
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    i_in_data,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    output logic          o_pmem_we,
    output logic [AW-1:0] o_pmem_addr,
    output logic [11:0]   o_pmem_wdata,
    output logic          o_core_clr,
    output logic          o_done,
    output logic          o_err,
    output logic [1:0]    o_err_code
);

    localparam logic [1:0]  c_ERR_NONE = 2'd0;
    localparam logic [1:0]  c_ERR_CSUM = 2'd1;
    localparam logic [1:0]  c_ERR_FMT  = 2'd2;
    localparam logic [1:0]  c_ERR_TMO  = 2'd3;
    // Largest legal word count: the whole 2^AW-word memory.
    localparam logic [16:0] c_NMAX     = 17'd1 << AW;

    typedef enum logic [2:0] {
        ST_HUNT  = 3'd0,
        ST_CNT_L = 3'd1,
        ST_CNT_H = 3'd2,
        ST_DAT_H = 3'd3,
        ST_DAT_L = 3'd4,
        ST_WR    = 3'd5,
        ST_CSUM  = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    state_t          r_state;
    logic [7:0]      r_cnt_l;
    logic [7:0]      r_sum;
    logic [3:0]      r_nib;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   r_last;
    logic [15:0]     r_idle;
    logic            r_in_ready;
    logic            r_pmem_we;
    logic [AW-1:0]   r_pmem_addr;
    logic [11:0]     r_pmem_wdata;
    logic            r_core_clr;
    logic            r_done;
    logic            r_err;
    logic [1:0]      r_err_code;

    logic            w_accept;
    logic [15:0]     w_n;
    logic [15:0]     w_n_m1;
    logic            w_n_bad;
    logic [7:0]      w_sum_next;
    logic            w_timed;
    logic            w_timeout;

    assign w_accept   = i_in_valid & r_in_ready;
    assign w_n        = {i_in_data, r_cnt_l};
    assign w_n_m1     = w_n - 16'd1;
    assign w_n_bad    = (w_n == 16'd0) || ({1'b0, w_n} > c_NMAX);
    assign w_sum_next = r_sum + i_in_data;

    // States that wait on the byte stream and are therefore subject to the
    // idle timeout. WR is excluded: it never waits for input.
    assign w_timed = (r_state == ST_CNT_L) || (r_state == ST_CNT_H) ||
                     (r_state == ST_DAT_H) || (r_state == ST_DAT_L) ||
                     (r_state == ST_CSUM);

    // Fires on the edge where the idle count would reach TIMEOUT, so the
    // error flags are visible exactly TIMEOUT cycles after the last byte.
    assign w_timeout = (TIMEOUT != 16'd0) && w_timed && !w_accept &&
                       (r_idle == TIMEOUT - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_HUNT;
            r_cnt_l      <= 8'd0;
            r_sum        <= 8'd0;
            r_nib        <= 4'd0;
            r_idx        <= '0;
            r_last       <= '0;
            r_idle       <= 16'd0;
            r_in_ready   <= 1'b1;
            r_pmem_we    <= 1'b0;
            r_pmem_addr  <= '0;
            r_pmem_wdata <= 12'd0;
            r_core_clr   <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= c_ERR_NONE;
        end else begin
            r_pmem_we  <= 1'b0;
            r_in_ready <= 1'b1;

            if (w_accept) begin
                r_idle <= 16'd0;
            end else if (w_timed) begin
                r_idle <= r_idle + 16'd1;
            end

            if (w_timeout) begin
                r_err      <= 1'b1;
                r_err_code <= c_ERR_TMO;
                r_idle     <= 16'd0;
                r_state    <= ST_HUNT;
            end else begin
                case (r_state)
                    ST_HUNT: begin
                        if (w_accept && (i_in_data == SYNC)) begin
                            r_err      <= 1'b0;
                            r_err_code <= c_ERR_NONE;
                            r_sum      <= 8'd0;
                            r_idx      <= '0;
                            r_state    <= ST_CNT_L;
                        end
                    end
                    ST_CNT_L: begin
                        if (w_accept) begin
                            r_cnt_l <= i_in_data;
                            r_sum   <= w_sum_next;
                            r_state <= ST_CNT_H;
                        end
                    end
                    ST_CNT_H: begin
                        if (w_accept) begin
                            r_sum <= w_sum_next;
                            if (w_n_bad) begin
                                r_err      <= 1'b1;
                                r_err_code <= c_ERR_FMT;
                                r_state    <= ST_HUNT;
                            end else begin
                                // N-1 fits in AW bits once N <= 2^AW.
                                r_last  <= w_n_m1[AW-1:0];
                                r_state <= ST_DAT_H;
                            end
                        end
                    end
                    ST_DAT_H: begin
                        if (w_accept) begin
                            if (i_in_data[7:4] != 4'd0) begin
                                r_err      <= 1'b1;
                                r_err_code <= c_ERR_FMT;
                                r_state    <= ST_HUNT;
                            end else begin
                                r_nib   <= i_in_data[3:0];
                                r_sum   <= w_sum_next;
                                r_state <= ST_DAT_L;
                            end
                        end
                    end
                    ST_DAT_L: begin
                        if (w_accept) begin
                            r_sum        <= w_sum_next;
                            r_pmem_we    <= 1'b1;
                            r_pmem_addr  <= r_idx;
                            r_pmem_wdata <= {r_nib, i_in_data};
                            // Registered ready: low for exactly the WR cycle.
                            r_in_ready   <= 1'b0;
                            r_state      <= ST_WR;
                        end
                    end
                    ST_WR: begin
                        r_idx  <= r_idx + 1'b1;
                        r_idle <= 16'd0;
                        if (r_idx == r_last) begin
                            r_state <= ST_CSUM;
                        end else begin
                            r_state <= ST_DAT_H;
                        end
                    end
                    ST_CSUM: begin
                        if (w_accept) begin
                            if (w_sum_next == 8'd0) begin
                                r_done     <= 1'b1;
                                r_core_clr <= 1'b0;
                                r_state    <= ST_DONE;
                            end else begin
                                r_err      <= 1'b1;
                                r_err_code <= c_ERR_CSUM;
                                r_state    <= ST_HUNT;
                            end
                        end
                    end
                    ST_DONE: begin
                        // Terminal until reset; bytes are accepted and dropped.
                    end
                    default: begin
                        r_state <= ST_HUNT;
                    end
                endcase
            end
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_pmem_we    = r_pmem_we;
    assign o_pmem_addr  = r_pmem_addr;
    assign o_pmem_wdata = r_pmem_wdata;
    assign o_core_clr   = r_core_clr;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_err_code   = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_pmem_loader.sv
// ============================================================================
// Module      : tb_pmem_loader
// Description : Self-checking directed testbench for pmem_loader. Each
//               scenario task drives a byte stream and compares outputs
//               against hand-computed values. A negedge monitor records
//               every program-memory write for later comparison.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pmem_loader;

    localparam int          c_AW      = 11;
    localparam logic [15:0] c_TIMEOUT = 16'd100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        i_in_data = 8'd0;
    logic              i_in_valid = 1'b0;
    logic              o_in_ready;
    logic              o_pmem_we;
    logic [c_AW-1:0]   o_pmem_addr;
    logic [11:0]       o_pmem_wdata;
    logic              o_core_clr;
    logic              o_done;
    logic              o_err;
    logic [1:0]        o_err_code;

    int total = 0;
    int bad   = 0;

    logic [c_AW-1:0] wq_addr[$];
    logic [11:0]     wq_data[$];

    // Reset-state vector: we, addr, wdata, core_clr, done, err, err_code, ready
    localparam logic [29:0] c_RST_VEC = {1'b0, 11'd0, 12'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};

    pmem_loader #(
        .AW      (c_AW),
        .SYNC    (8'hA5),
        .TIMEOUT (c_TIMEOUT)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_in_data    (i_in_data),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .o_pmem_we    (o_pmem_we),
        .o_pmem_addr  (o_pmem_addr),
        .o_pmem_wdata (o_pmem_wdata),
        .o_core_clr   (o_core_clr),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_err_code   (o_err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && o_pmem_we) begin
            wq_addr.push_back(o_pmem_addr);
            wq_data.push_back(o_pmem_wdata);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    task automatic do_reset();
        i_in_valid = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wq_addr.delete();
        wq_data.delete();
    endtask

    // Present one byte after 'gap' idle cycles and hold it until accepted.
    // Returns 1 ns after the accepting clock edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        i_in_data  = b;
        i_in_valid = 1'b1;
        n = 0;
        while (!o_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!o_in_ready) begin
            total++;
            bad++;
            $display("FAIL handshake: in_ready=%b after %0d cycles, required 1", o_in_ready, n);
        end
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] s[$]);
        foreach (s[i]) send_byte(s[i], 0);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({o_pmem_we, o_pmem_addr, o_pmem_wdata, o_core_clr, o_done, o_err, o_err_code, o_in_ready} !== c_RST_VEC) begin
            bad++;
            $display("FAIL reset_state: got=%h required=%h",
                     {o_pmem_we, o_pmem_addr, o_pmem_wdata, o_core_clr, o_done, o_err, o_err_code, o_in_ready}, c_RST_VEC);
        end
    endtask

    // Checksum covers the count bytes and data:
    // 02+00+0C+25+01+FF+CD = 0x200 -> 0 mod 256.
    task automatic test_good_frame();
        do_reset();
        send_seq('{8'h00, 8'hFF, 8'h5A});
        total++;
        if (wq_addr.size() != 0 || o_core_clr !== 1'b1 || o_err !== 1'b0) begin
            bad++;
            $display("FAIL junk_discard: writes=%0d clr=%b err=%b required 0/1/0", wq_addr.size(), o_core_clr, o_err);
        end
        send_seq('{8'hA5, 8'h02, 8'h00, 8'h0C, 8'h25});
        total++;
        if ({o_pmem_we, o_pmem_addr, o_pmem_wdata} !== {1'b1, 11'h000, 12'hC25}) begin
            bad++;
            $display("FAIL write0: we=%b addr=%h data=%h required 1/000/C25", o_pmem_we, o_pmem_addr, o_pmem_wdata);
        end
        send_seq('{8'h01, 8'hFF});
        total++;
        if ({o_pmem_we, o_pmem_addr, o_pmem_wdata} !== {1'b1, 11'h001, 12'h1FF}) begin
            bad++;
            $display("FAIL write1: we=%b addr=%h data=%h required 1/001/1FF", o_pmem_we, o_pmem_addr, o_pmem_wdata);
        end
        total++;
        if (o_done !== 1'b0 || o_core_clr !== 1'b1) begin
            bad++;
            $display("FAIL pre_csum: done=%b clr=%b required 0/1", o_done, o_core_clr);
        end
        send_byte(8'hCD, 0);
        total++;
        if ({o_done, o_core_clr, o_err} !== 3'b100) begin
            bad++;
            $display("FAIL good_done: done/clr/err=%b required 100", {o_done, o_core_clr, o_err});
        end
        total++;
        if (wq_addr.size() != 2) begin
            bad++;
            $display("FAIL good_wcount: got=%0d required=2", wq_addr.size());
        end
        // Terminal state: further bytes accepted and dropped.
        send_seq('{8'hA5, 8'h01, 8'h00});
        total++;
        if (o_done !== 1'b1 || o_in_ready !== 1'b1 || wq_addr.size() != 2) begin
            bad++;
            $display("FAIL done_sticky: done=%b ready=%b writes=%0d required 1/1/2", o_done, o_in_ready, wq_addr.size());
        end
    endtask

    task automatic test_bad_csum();
        do_reset();
        send_seq('{8'hA5, 8'h02, 8'h00, 8'h0C, 8'h25, 8'h01, 8'hFF, 8'h00});
        total++;
        if (wq_addr.size() != 2) begin
            bad++;
            $display("FAIL badcsum_wcount: got=%0d required=2", wq_addr.size());
        end
        total++;
        if ({o_err, o_err_code, o_core_clr, o_done} !== 5'b1_01_1_0) begin
            bad++;
            $display("FAIL badcsum_flags: err/code/clr/done=%b required 10110", {o_err, o_err_code, o_core_clr, o_done});
        end
    endtask

    task automatic test_format();
        do_reset();
        send_seq('{8'hA5, 8'h00, 8'h00});
        total++;
        if ({o_err, o_err_code} !== 3'b1_10) begin
            bad++;
            $display("FAIL fmt_zero_count: err/code=%b required 110", {o_err, o_err_code});
        end
        send_byte(8'hA5, 0);
        total++;
        if ({o_err, o_err_code} !== 3'b0_00) begin
            bad++;
            $display("FAIL sync_clears_err: err/code=%b required 000", {o_err, o_err_code});
        end
        send_seq('{8'h01, 8'h00, 8'h1C});
        total++;
        if ({o_err, o_err_code} !== 3'b1_10 || wq_addr.size() != 0) begin
            bad++;
            $display("FAIL fmt_hi_nibble: err/code=%b writes=%0d required 110/0", {o_err, o_err_code}, wq_addr.size());
        end
        send_seq('{8'hA5, 8'h02, 8'h00, 8'h0C, 8'h25, 8'h01, 8'hFF, 8'hCD});
        total++;
        if ({o_done, o_core_clr, o_err} !== 3'b100 || wq_addr.size() != 2) begin
            bad++;
            $display("FAIL fmt_recover: done/clr/err=%b writes=%0d required 100/2", {o_done, o_core_clr, o_err}, wq_addr.size());
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send_seq('{8'hA5, 8'h01, 8'h00});
        repeat (99) @(posedge clk);
        #1;
        total++;
        if (o_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early: err=%b at 99 cycles, required 0", o_err);
        end
        @(posedge clk);
        #1;
        total++;
        if ({o_err, o_err_code} !== 3'b1_11) begin
            bad++;
            $display("FAIL timeout_fire: err/code=%b at 100 cycles, required 111", {o_err, o_err_code});
        end
        // Back in HUNT: a complete frame must now load.
        send_seq('{8'hA5, 8'h02, 8'h00, 8'h0C, 8'h25, 8'h01, 8'hFF, 8'hCD});
        total++;
        if ({o_done, o_err} !== 2'b10) begin
            bad++;
            $display("FAIL timeout_recover: done/err=%b required 10", {o_done, o_err});
        end
    endtask

    // Three words sent back-to-back, one containing the SYNC value as data.
    // SYNC accept edge E0 to CSUM accept edge: 2 count + 3 x (HI, LO, WR) + 1 = 12.
    // Checksum: 03+00+00+00+0F+FF+05+A5 = 0x1BB, CSUM = 0x45.
    task automatic test_back_to_back();
        realtime t0;
        realtime t1;
        do_reset();
        send_byte(8'hA5, 0);
        t0 = $realtime;
        send_seq('{8'h03, 8'h00, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'h05, 8'hA5, 8'h45});
        t1 = $realtime;
        total++;
        if ((t1 - t0) != 120.0) begin
            bad++;
            $display("FAIL b2b_cycles: got=%0d required=12", int'((t1 - t0) / 10.0));
        end
        total++;
        if (wq_addr.size() != 3 || o_done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_done: writes=%0d done=%b required 3/1", wq_addr.size(), o_done);
        end else if (wq_data[0] !== 12'h000 || wq_data[1] !== 12'hFFF || wq_data[2] !== 12'h5A5 || wq_addr[2] !== 11'h002) begin
            bad++;
            $display("FAIL b2b_data: %h %h %h @%h required 000 FFF 5A5 @002", wq_data[0], wq_data[1], wq_data[2], wq_addr[2]);
        end
    endtask

    task automatic test_big_frame();
        logic [7:0]  sum;
        logic [11:0] w;
        int          bad_entries;
        do_reset();
        sum = 8'h00 + 8'h08;
        send_byte(8'hA5, 0);
        send_byte(8'h00, $urandom_range(0, 5));
        send_byte(8'h08, $urandom_range(0, 5));
        for (int i = 0; i < 2048; i++) begin
            w   = 12'(i * 695 + 21);
            sum = sum + {4'd0, w[11:8]} + w[7:0];
            send_byte({4'd0, w[11:8]}, $urandom_range(0, 5));
            send_byte(w[7:0], $urandom_range(0, 5));
        end
        send_byte(8'h00 - sum, $urandom_range(0, 5));
        total++;
        if (wq_addr.size() != 2048) begin
            bad++;
            $display("FAIL big_wcount: got=%0d required=2048", wq_addr.size());
        end else begin
            bad_entries = 0;
            for (int i = 0; i < 2048; i++) begin
                w = 12'(i * 695 + 21);
                if (wq_addr[i] !== 11'(i) || wq_data[i] !== w) bad_entries++;
            end
            if (bad_entries != 0) begin
                bad++;
                $display("FAIL big_contents: %0d wrong entries, required 0", bad_entries);
            end
        end
        total++;
        if ({o_done, o_core_clr, o_err} !== 3'b100) begin
            bad++;
            $display("FAIL big_done: done/clr/err=%b required 100", {o_done, o_core_clr, o_err});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_seq('{8'hA5, 8'h05, 8'h00, 8'h01, 8'h11, 8'h02, 8'h22, 8'h03, 8'h33, 8'h04, 8'h44});
        total++;
        if ({o_pmem_we, o_pmem_addr, o_pmem_wdata} !== {1'b1, 11'h003, 12'h444}) begin
            bad++;
            $display("FAIL mid_write3: we=%b addr=%h data=%h required 1/003/444", o_pmem_we, o_pmem_addr, o_pmem_wdata);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({o_pmem_we, o_pmem_addr, o_pmem_wdata, o_core_clr, o_done, o_err, o_err_code, o_in_ready} !== c_RST_VEC) begin
            bad++;
            $display("FAIL mid_async_reset: got=%h required=%h",
                     {o_pmem_we, o_pmem_addr, o_pmem_wdata, o_core_clr, o_done, o_err, o_err_code, o_in_ready}, c_RST_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wq_addr.delete();
        wq_data.delete();
        send_seq('{8'hA5, 8'h02, 8'h00, 8'h0C, 8'h25, 8'h01, 8'hFF, 8'hCD});
        total++;
        if (o_done !== 1'b1 || wq_addr.size() != 2) begin
            bad++;
            $display("FAIL mid_reload: done=%b writes=%0d required 1/2", o_done, wq_addr.size());
        end else if (wq_addr[0] !== 11'h000 || wq_data[0] !== 12'hC25 || wq_addr[1] !== 11'h001 || wq_data[1] !== 12'h1FF) begin
            bad++;
            $display("FAIL mid_reload_data: %h<-%h %h<-%h required 000<-C25 001<-1FF", wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
        end
        // Reset from DONE must re-hold the core immediately.
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({o_core_clr, o_done} !== 2'b10) begin
            bad++;
            $display("FAIL done_reset: clr/done=%b required 10", {o_core_clr, o_done});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_format();
        test_timeout();
        test_back_to_back();
        test_big_frame();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
